// File: rtl/seg_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_frame_pkg
// Description : Shared constants for the six-digit 7-segment frame writer.
//               Segment codes are {a,b,c,d,e,f,g} with active-high segments.
//               The package also holds the mode and position codes and the
//               field limits.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_frame_pkg;

    // Segment patterns, bit 6 = a ... bit 0 = g
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    // Display modes (codes 10/11 are folded into MODE_CLOCK by the writer)
    localparam logic [1:0] MODE_CLOCK = 2'b00;
    localparam logic [1:0] MODE_SET   = 2'b01;

    // Field selected for editing
    localparam logic [1:0] POS_SEC  = 2'b00;
    localparam logic [1:0] POS_MIN  = 2'b01;
    localparam logic [1:0] POS_HOUR = 2'b10;
    localparam logic [1:0] POS_NONE = 2'b11;

    // Largest legal value of each field
    localparam logic [5:0] LIMIT_MIN_SEC = 6'd59;
    localparam logic [5:0] LIMIT_HOUR    = 6'd23;

    // Digit code used to request a dash from the encoder
    localparam logic [3:0] DIGIT_DASH = 4'hF;

    // Split a binary field into {tens, ones}; out-of-range values become a
    // pair of dash requests.
    function automatic logic [7:0] bcd_split(input logic [5:0] value,
                                             input logic [5:0] limit);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(value / 6'd10);
        ones = 4'(value % 6'd10);
        if (value > limit) begin
            return {DIGIT_DASH, DIGIT_DASH};
        end
        return {tens, ones};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_seg_enc.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seg_enc
// Description : Combinational decimal digit to 7-segment encoder.
//               Codes 10..15 produce a dash.
// Ports       : i_digit [3:0] - digit value
//               o_seg   [6:0] - segment pattern {a,b,c,d,e,f,g}
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_seg_enc
    import seg_frame_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_frame_builder.sv
`default_nettype none
// ============================================================================
// Module      : seg_frame_builder
// Description : Writer side of the six-digit 7-segment display bus. Converts
//               binary hour/min/sec into a 42-bit segment frame plus a 6-bit
//               dp vector, blinks the field being edited in setting mode and
//               commits a new frame only on the multiplexer frame-sync pulse.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_sec/i_min/i_hour  - binary time fields
//               i_mode              - 00 clock, 01 setting, others = clock
//               i_position          - edited field: 00 sec 01 min 10 hour
//               i_alarm_en          - alarm armed, shown on dp[0]
//               i_frame_sync        - commit strobe from display mux
//               o_six_digit_seg     - {hL,hR,mL,mR,sL,sR}, [6:0] = sec-R
//               o_six_dp            - per-digit dp, bit0 = sec-R
//               o_frame_valid       - set by the first commit after reset
// Revision    : 1.0 - initial release
// ============================================================================
module seg_frame_builder
    import seg_frame_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000,
    parameter int BLINK_CW  = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  i_sec,
    input  logic [5:0]  i_min,
    input  logic [5:0]  i_hour,
    input  logic [1:0]  i_mode,
    input  logic [1:0]  i_position,
    input  logic        i_alarm_en,
    input  logic        i_frame_sync,
    output logic [41:0] o_six_digit_seg,
    output logic [5:0]  o_six_dp,
    output logic        o_frame_valid
);

    localparam logic [BLINK_CW-1:0] c_blink_last = BLINK_CW'(BLINK_DIV - 1);

    // ------------------------------------------------------------------
    // Stage 1: registered inputs split into decimal digits.
    // Digit index 0 = sec-R ... 5 = hour-L.
    // ------------------------------------------------------------------
    logic [5:0][3:0] r_s1_dig;
    logic [1:0]      r_s1_mode;
    logic [1:0]      r_s1_pos;
    logic            r_s1_alarm;
    logic [1:0]      w_mode_in;

    // Unsupported mode codes behave as clock mode.
    assign w_mode_in = (i_mode == MODE_SET) ? MODE_SET : MODE_CLOCK;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_dig   <= '0;
            r_s1_mode  <= MODE_CLOCK;
            r_s1_pos   <= POS_SEC;
            r_s1_alarm <= 1'b0;
        end else begin
            r_s1_dig[1:0] <= bcd_split(i_sec,  LIMIT_MIN_SEC);
            r_s1_dig[3:2] <= bcd_split(i_min,  LIMIT_MIN_SEC);
            r_s1_dig[5:4] <= bcd_split(i_hour, LIMIT_HOUR);
            r_s1_mode     <= w_mode_in;
            r_s1_pos      <= i_position;
            r_s1_alarm    <= i_alarm_en;
        end
    end

    // ------------------------------------------------------------------
    // Blink timebase. A new field selection or entry into setting mode
    // restarts the half-period in the visible phase, so the field the user
    // just picked is never blank on arrival.
    // ------------------------------------------------------------------
    logic [BLINK_CW-1:0] r_blink_cnt;
    logic                r_blink_phase;
    logic                w_blink_restart;

    assign w_blink_restart = (i_position != r_s1_pos) ||
                             ((w_mode_in == MODE_SET) && (r_s1_mode != MODE_SET));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_blink_restart) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: encode, mask and build the staging frame.
    // ------------------------------------------------------------------
    logic [41:0] w_stage_seg;
    logic [5:0]  w_stage_dp;
    logic        w_mask_en;
    logic        w_sep;

    assign w_mask_en = (r_s1_mode == MODE_SET) && r_blink_phase &&
                       (r_s1_pos != POS_NONE);
    assign w_sep     = (r_s1_mode == MODE_CLOCK);
    assign w_stage_dp = {1'b0, w_sep, 1'b0, w_sep, 1'b0, r_s1_alarm};

    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
        // Two digits per field: 0/1 sec, 2/3 min, 4/5 hour
        localparam logic [1:0] c_field = 2'(gi / 2);
        logic [6:0] w_code;

        bcd_seg_enc u_enc (
            .i_digit (r_s1_dig[gi]),
            .o_seg   (w_code)
        );

        assign w_stage_seg[gi*7 +: 7] =
            (w_mask_en && (r_s1_pos == c_field)) ? SEG_BLANK : w_code;
    end

    logic [41:0] r_stg_seg;
    logic [5:0]  r_stg_dp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_seg <= '0;
            r_stg_dp  <= '0;
        end else begin
            r_stg_seg <= w_stage_seg;
            r_stg_dp  <= w_stage_dp;
        end
    end

    // ------------------------------------------------------------------
    // Commit: the outputs change only on frame sync, so a scan in progress
    // never sees a mixture of old and new digits.
    // ------------------------------------------------------------------
    logic [41:0] r_seg;
    logic [5:0]  r_dp;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg   <= '0;
            r_dp    <= '0;
            r_valid <= 1'b0;
        end else if (i_frame_sync) begin
            r_seg   <= r_stg_seg;
            r_dp    <= r_stg_dp;
            r_valid <= 1'b1;
        end
    end

    assign o_six_digit_seg = r_seg;
    assign o_six_dp        = r_dp;
    assign o_frame_valid   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_seg_frame_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_frame_builder
// Description : Scoreboard bench for seg_frame_builder. The stimulus process
//               pushes the expected frame for every sync it issues; a monitor
//               pops and compares after each committing clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_frame_builder;

    typedef struct packed {
        logic [41:0] seg;
        logic [5:0]  dp;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  i_sec, i_min, i_hour;
    logic [1:0]  i_mode, i_position;
    logic        i_alarm_en, i_frame_sync;
    logic [41:0] o_six_digit_seg;
    logic [5:0]  o_six_dp;
    logic        o_frame_valid;

    int total = 0;
    int bad   = 0;
    frame_t exp_q[$];

    seg_frame_builder #(
        .BLINK_DIV (4),
        .BLINK_CW  (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_sec           (i_sec),
        .i_min           (i_min),
        .i_hour          (i_hour),
        .i_mode          (i_mode),
        .i_position      (i_position),
        .i_alarm_en      (i_alarm_en),
        .i_frame_sync    (i_frame_sync),
        .o_six_digit_seg (o_six_digit_seg),
        .o_six_dp        (o_six_dp),
        .o_frame_valid   (o_frame_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Independent digit table
    function automatic logic [6:0] dseg(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000001;
        endcase
    endfunction

    function automatic logic [13:0] pair(input int v, input int lim, input bit blank);
        if (blank) return 14'd0;
        if (v > lim) return {7'b0000001, 7'b0000001};
        return {dseg(v / 10), dseg(v % 10)};
    endfunction

    function automatic frame_t mk(input int h, input int m, input int s,
                                  input bit hb, input bit mb, input bit sb,
                                  input bit clock_mode, input bit alarm);
        frame_t f;
        f.seg = {pair(h, 23, hb), pair(m, 59, mb), pair(s, 59, sb)};
        f.dp  = {1'b0, clock_mode, 1'b0, clock_mode, 1'b0, alarm};
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string name, input frame_t f, input bit valid);
        check({name, ".seg"},   64'(o_six_digit_seg), 64'(f.seg));
        check({name, ".dp"},    64'(o_six_dp),        64'(f.dp));
        check({name, ".valid"}, 64'(o_frame_valid),   64'(valid));
    endtask

    // Monitor: every non-reset edge with sync high is a commit
    always @(posedge clk) begin
        if (!rst && i_frame_sync) begin
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL commit: got unexpected commit, expected none (t=%0t)", $time);
            end else begin
                check_frame("commit", exp_q.pop_front(), 1'b1);
            end
        end
    end

    initial begin
        frame_t zero_f;
        frame_t f10;
        zero_f = '0;
        rst = 1'b1; i_frame_sync = 1'b0; i_alarm_en = 1'b0;
        i_hour = 6'd12; i_min = 6'd34; i_sec = 6'd56;
        i_mode = 2'b00; i_position = 2'b11;

        // Test 1: reset then first commit
        repeat (3) tick();
        check_frame("reset", zero_f, 1'b0);
        rst = 1'b0;
        tick(); tick();
        check_frame("pre_sync", zero_f, 1'b0);
        i_frame_sync = 1'b1;
        exp_q.push_back(mk(12, 34, 56, 0, 0, 0, 1, 0));
        tick();

        // Tests 2/3: minute blink, then move to hour mid-blank
        i_min = 6'd7; i_mode = 2'b01; i_position = 2'b01;
        for (int k = 0; k < 18; k++) begin
            if (k == 6) i_position = 2'b10;
            if (k < 2)       exp_q.push_back(mk(12, 34, 56, 0, 0, 0, 1, 0));
            else if (k < 6)  exp_q.push_back(mk(12, 7, 56, 0, 0, 0, 0, 0));
            else if (k < 8)  exp_q.push_back(mk(12, 7, 56, 0, 1, 0, 0, 0));
            else if (k < 12) exp_q.push_back(mk(12, 7, 56, 0, 0, 0, 0, 0));
            else if (k < 16) exp_q.push_back(mk(12, 7, 56, 1, 0, 0, 0, 0));
            else             exp_q.push_back(mk(12, 7, 56, 0, 0, 0, 0, 0));
            tick();
        end
        i_frame_sync = 1'b0;

        // Test 4: hold without sync, commit latency
        i_mode = 2'b10; i_position = 2'b11; i_min = 6'd34; i_sec = 6'd10;
        repeat (3) tick();
        i_frame_sync = 1'b1;
        exp_q.push_back(mk(12, 34, 10, 0, 0, 0, 1, 0));
        tick();
        i_frame_sync = 1'b0;
        i_sec = 6'd11;
        tick();
        i_frame_sync = 1'b1;
        exp_q.push_back(mk(12, 34, 10, 0, 0, 0, 1, 0));
        tick();
        i_frame_sync = 1'b0;
        f10 = mk(12, 34, 10, 0, 0, 0, 1, 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("hold.seg", 64'(o_six_digit_seg), 64'(f10.seg));
        end
        i_frame_sync = 1'b1;
        exp_q.push_back(mk(12, 34, 11, 0, 0, 0, 1, 0));
        tick();
        i_frame_sync = 1'b0;
        i_sec = 6'd12;
        tick(); tick();
        i_frame_sync = 1'b1;
        exp_q.push_back(mk(12, 34, 12, 0, 0, 0, 1, 0));
        tick();
        i_frame_sync = 1'b0;

        // Test 5: out-of-range fields and limits
        i_hour = 6'd24; i_min = 6'd60; i_sec = 6'd12;
        tick(); tick(); i_frame_sync = 1'b1;
        exp_q.push_back(mk(24, 60, 12, 0, 0, 0, 1, 0));
        tick(); i_frame_sync = 1'b0;
        i_hour = 6'd23; i_min = 6'd59; i_sec = 6'd60;
        tick(); tick(); i_frame_sync = 1'b1;
        exp_q.push_back(mk(23, 59, 60, 0, 0, 0, 1, 0));
        tick(); i_frame_sync = 1'b0;
        i_hour = 6'd63; i_min = 6'd0; i_sec = 6'd59; i_mode = 2'b11;
        tick(); tick(); i_frame_sync = 1'b1;
        exp_q.push_back(mk(63, 0, 59, 0, 0, 0, 1, 0));
        tick(); i_frame_sync = 1'b0;

        // Test 6: reset mid-blink with alarm armed
        i_hour = 6'd12; i_min = 6'd34; i_sec = 6'd56;
        i_mode = 2'b01; i_position = 2'b00; i_alarm_en = 1'b1;
        tick(); tick();
        i_frame_sync = 1'b1;
        for (int k = 2; k < 7; k++) begin
            exp_q.push_back(mk(12, 34, 56, 0, 0, (k == 6), 0, 1));
            tick();
        end
        rst = 1'b1;
        tick();
        check_frame("mid_reset", zero_f, 1'b0);
        rst = 1'b0; i_frame_sync = 1'b0;
        tick();
        check_frame("post_reset", zero_f, 1'b0);
        tick();
        i_frame_sync = 1'b1;
        for (int k = 10; k < 15; k++) begin
            exp_q.push_back(mk(12, 34, 56, 0, 0, (k == 14), 0, 1));
            tick();
        end
        i_frame_sync = 1'b0;
        tick(); tick();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending frames, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
